// File: rtl/mio_bus_arbiter.sv
// Two-master round-robin arbiter for the single MIO bus; one transfer granted at a time.
// Latency: a request seen at edge N drives s_req from cycle N+1; completion is returned combinationally.
// Backpressure: the granted master holds req until ready, and the other master waits in its request.
//
// Ports: clk/reset (async active-high); m0_* and m1_* master request/response channels;
//        s_* slave channel; gnt one-hot {m1,m0} grant; err timeout pulse.
// Build option: define MIO_ARB_TIMEOUT_EN to enable the busy-cycle timeout (err pulse,
//        forced all-ones read data). When it is undefined, err is tied to 0.
module mio_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    output logic [1:0]        gnt,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t state, state_nxt;
    // Index of the master that last completed a transfer; the other one wins a tie.
    logic   last_gnt, last_gnt_nxt;
    logic   tmo;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("mio_bus_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

`ifdef MIO_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [CNT_W-1:0] busy_cnt;

    // Counts completed BUSY cycles without s_ready; held at 0 in IDLE so every grant starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (state == IDLE) begin
            busy_cnt <= '0;
        end else if (!s_ready) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    // busy_cnt == TIMEOUT_CYCLES-1 means this is the TIMEOUT_CYCLES-th BUSY cycle.
    assign tmo = (state != IDLE) && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    logic sel;
    logic req_sel;

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        gnt          = 2'b00;
        s_req        = 1'b0;
        s_we         = 1'b0;
        s_addr       = '0;
        s_wdata      = '0;
        m0_ready     = 1'b0;
        m1_ready     = 1'b0;
        m0_rdata     = '0;
        m1_rdata     = '0;
        err          = 1'b0;
        sel          = (state == BUSY1);
        req_sel      = sel ? m1_req : m0_req;

        if (state == IDLE) begin
            // s_ready is deliberately ignored here.
            if (m0_req && m1_req) begin
                state_nxt = last_gnt ? BUSY0 : BUSY1;
            end else if (m0_req) begin
                state_nxt = BUSY0;
            end else if (m1_req) begin
                state_nxt = BUSY1;
            end
        end else begin
            gnt[sel] = 1'b1;
            s_req    = 1'b1;
            s_we     = sel ? m1_we    : m0_we;
            s_addr   = sel ? m1_addr  : m0_addr;
            s_wdata  = sel ? m1_wdata : m0_wdata;
            if (sel) m1_rdata = s_rdata;
            else     m0_rdata = s_rdata;

            if (s_ready) begin
                if (sel) m1_ready = 1'b1;
                else     m0_ready = 1'b1;
                last_gnt_nxt = sel;
                state_nxt    = IDLE;
            end else if (!req_sel) begin
                // Abort: the master withdrew; no completion and fairness history untouched.
                state_nxt = IDLE;
            end else if (tmo) begin
                if (sel) begin
                    m1_ready = 1'b1;
                    m1_rdata = '1;
                end else begin
                    m0_ready = 1'b1;
                    m0_rdata = '1;
                end
                err          = 1'b1;
                last_gnt_nxt = sel;
                state_nxt    = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed self-checking bench for mio_bus_arbiter.
// Latency: inputs driven #1 after rising edges, outputs sampled #1 later.
// Backpressure: slave s_ready is driven directly by the bench.
module tb_mio_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ready, m1_ready;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_req, s_we, s_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [1:0]    gnt;
    logic          err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .gnt(gnt), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    32'(gnt),      32'h0);
        chk({tag, "_sreq"},   32'(s_req),    32'h0);
        chk({tag, "_swe"},    32'(s_we),     32'h0);
        chk({tag, "_saddr"},  s_addr,        32'h0);
        chk({tag, "_swdata"}, s_wdata,       32'h0);
        chk({tag, "_m0rdy"},  32'(m0_ready), 32'h0);
        chk({tag, "_m1rdy"},  32'(m1_ready), 32'h0);
        chk({tag, "_m0rd"},   m0_rdata,      32'h0);
        chk({tag, "_m1rd"},   m1_rdata,      32'h0);
        chk({tag, "_err"},    32'(err),      32'h0);
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        s_ready = 0; s_rdata = 32'hCAFE_0001;

        // Reset while idle
        #1;
        chk_all_zero("rst_idle");
        step(); step();
        rst = 1'b0;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'h0);

        // m0 read of 0x10, slave answers 3 cycles after s_req rises
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010;
        #1;
        chk("rd_idle_gnt", 32'(gnt), 32'h0);
        step();
        chk("rd_gnt",   32'(gnt),   32'h1);
        chk("rd_sreq",  32'(s_req), 32'h1);
        chk("rd_saddr", s_addr,     32'h0000_0010);
        chk("rd_swe",   32'(s_we),  32'h0);
        chk("rd_wait1_rdy", 32'(m0_ready), 32'h0);
        step();
        chk("rd_wait2_rdy", 32'(m0_ready), 32'h0);
        step();
        chk("rd_wait3_rdy", 32'(m0_ready), 32'h0);
        step();
        s_ready = 1; s_rdata = 32'h1234_5678;
        #1;
        chk("rd_m0rdy",  32'(m0_ready), 32'h1);
        chk("rd_m0rd",   m0_rdata,      32'h1234_5678);
        chk("rd_m1rdy",  32'(m1_ready), 32'h0);
        chk("rd_m1rd",   m1_rdata,      32'h0);
        chk("rd_err",    32'(err),      32'h0);
        step();
        m0_req = 0; s_ready = 0;
        #1;
        chk("rd_after_gnt",  32'(gnt),      32'h0);
        chk("rd_after_rdy",  32'(m0_ready), 32'h0);

        // Reset in the middle of a BUSY1 transfer
        step();
        m1_req = 1; m1_addr = 32'h0000_0020;
        step();
        chk("mid_busy_gnt", 32'(gnt), 32'h2);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_busy");
        m1_req = 0;
        step();
        rst = 1'b0;
        step();
        chk("rst_busy_idle", 32'(gnt), 32'h0);

        // Both masters held, slave ready at once: alternate with a gnt=00 gap
        m0_req = 1; m1_req = 1; s_ready = 1; s_rdata = 32'h0BAD_F00D;
        m0_addr = 32'h100; m1_addr = 32'h200;
        begin
            logic [1:0] order [4];
            order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
            for (int i = 0; i < 4; i++) begin
                step();
                chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(order[i]));
                chk($sformatf("rr_rdy%0d", i), 32'({m1_ready, m0_ready}), 32'(order[i]));
                step();
                if (i == 3) begin
                    m0_req = 0; m1_req = 0; s_ready = 0;
                end
                chk($sformatf("rr_gap%0d", i), 32'(gnt), 32'h0);
            end
        end

        // m1 write held while m0 requests mid-transfer
        m1_req = 1; m1_we = 1; m1_addr = 32'h8000_0000; m1_wdata = 32'hA5A5_A5A5;
        step();
        chk("wr_gnt", 32'(gnt), 32'h2);
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0044; m0_wdata = 32'h0000_0011;
        #1;
        chk("wr_saddr", s_addr,        32'h8000_0000);
        chk("wr_swd",   s_wdata,       32'hA5A5_A5A5);
        chk("wr_swe",   32'(s_we),     32'h1);
        chk("wr_m0rdy", 32'(m0_ready), 32'h0);
        step();
        chk("wr_hold_gnt",   32'(gnt),  32'h2);
        chk("wr_hold_saddr", s_addr,    32'h8000_0000);
        step();
        s_ready = 1; s_rdata = 32'h0;
        #1;
        chk("wr_m1rdy", 32'(m1_ready), 32'h1);
        chk("wr_m0rdy2", 32'(m0_ready), 32'h0);
        step();
        m1_req = 0; m1_we = 0; s_ready = 0;
        #1;
        chk("wr_gap_gnt", 32'(gnt), 32'h0);
        step();
        chk("wr_next_gnt",   32'(gnt), 32'h1);
        chk("wr_next_saddr", s_addr,   32'h0000_0044);
        s_ready = 1; s_rdata = 32'h0000_5555;
        #1;
        chk("wr_next_rdy", 32'(m0_ready), 32'h1);
        step();
        m0_req = 0; s_ready = 0;

        // Single m1 transfer so that m0 is the preferred tie winner again
        step();
        m1_req = 1;
        step();
        s_ready = 1;
        #1;
        chk("pre_ab_m1rdy", 32'(m1_ready), 32'h1);
        step();
        m1_req = 0; s_ready = 0;

        // Abort: m0 drops req after one BUSY cycle
        step();
        m0_req = 1;
        step();
        chk("ab_sreq", 32'(s_req), 32'h1);
        m0_req = 0;
        #1;
        chk("ab_rdy0", 32'(m0_ready), 32'h0);
        step();
        chk("ab_sreq_drop", 32'(s_req),    32'h0);
        chk("ab_gnt",       32'(gnt),      32'h0);
        chk("ab_rdy1",      32'(m0_ready), 32'h0);
        m0_req = 1; m1_req = 1;
        step();
        chk("ab_tie_gnt", 32'(gnt), 32'h1);
        s_ready = 1;
        step();
        m0_req = 0; m1_req = 0; s_ready = 0;

        // Slave never answers
        step();
        s_rdata = 32'hDEAD_BEEF;
        m0_req = 1;
        step();
`ifdef MIO_ARB_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            chk($sformatf("to_rdy_c%0d", i), 32'(m0_ready), 32'h0);
            chk($sformatf("to_err_c%0d", i), 32'(err),      32'h0);
            step();
        end
        chk("to_rdy",  32'(m0_ready), 32'h1);
        chk("to_err",  32'(err),      32'h1);
        chk("to_rd",   m0_rdata,      32'hFFFF_FFFF);
        chk("to_sreq", 32'(s_req),    32'h1);
        step();
        m0_req = 0;
        #1;
        chk("to_idle_gnt", 32'(gnt), 32'h0);
        chk("to_idle_err", 32'(err), 32'h0);
`else
        for (int i = 0; i < 100; i++) begin
            chk($sformatf("hang_sreq_c%0d", i), 32'(s_req), 32'h1);
            chk($sformatf("hang_err_c%0d", i),  32'(err),   32'h0);
            step();
        end
        m0_req = 0;
        step();
        chk("hang_idle_gnt", 32'(gnt), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
